// File: rtl/biu_xbar_if.sv
// Bus bundle for biu_xbar: CPU request side, shared Wishbone-classic slave side,
// and the error status registers.
interface biu_xbar_if #(
    parameter int NSLV = 4,
    parameter int AW   = 32,
    parameter int DW   = 32
);
    // CPU side
    logic                 cpu_req_i;
    logic                 cpu_we_i;
    logic [DW/8-1:0]      cpu_sel_i;
    logic [AW-1:0]        cpu_adr_i;
    logic [DW-1:0]        cpu_dat_i;
    logic [DW-1:0]        cpu_dat_o;
    logic                 cpu_ready_o;
    logic                 cpu_err_o;
    // Slave side
    logic [NSLV-1:0]      s_cyc_o;
    logic [NSLV-1:0]      s_stb_o;
    logic                 s_we_o;
    logic [AW-1:0]        s_adr_o;
    logic [DW/8-1:0]      s_sel_o;
    logic [DW-1:0]        s_dat_o;
    logic [NSLV*DW-1:0]   s_dat_i;
    logic [NSLV-1:0]      s_ack_i;
    logic [NSLV-1:0]      s_err_i;
    // Status
    logic [AW-1:0]        err_adr_o;
    logic [7:0]           err_cnt_o;

    // View of the bus unit itself
    modport slave (
        input  cpu_req_i, cpu_we_i, cpu_sel_i, cpu_adr_i, cpu_dat_i,
        output cpu_dat_o, cpu_ready_o, cpu_err_o,
        output s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_sel_o, s_dat_o,
        input  s_dat_i, s_ack_i, s_err_i,
        output err_adr_o, err_cnt_o
    );

    // View of the surrounding environment (CPU plus peripherals)
    modport master (
        output cpu_req_i, cpu_we_i, cpu_sel_i, cpu_adr_i, cpu_dat_i,
        input  cpu_dat_o, cpu_ready_o, cpu_err_o,
        input  s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_sel_o, s_dat_o,
        output s_dat_i, s_ack_i, s_err_i,
        input  err_adr_o, err_cnt_o
    );
endinterface

// File: rtl/biu_xbar.sv
// Registered bus interface unit: routes one CPU request to one of NSLV
// Wishbone-classic slaves chosen by the top 4 address bits, with wait-state
// handshake, timeout, error response and error status registers.
module biu_xbar #(
    parameter int                NSLV     = 4,
    parameter int                AW       = 32,
    parameter int                DW       = 32,
    parameter logic [NSLV*4-1:0] SLV_TAGS = {4'hc, 4'h3, 4'h2, 4'h0},
    parameter int                TIMEOUT  = 255
) (
    input  logic         clk,
    input  logic         rst,
    biu_xbar_if.slave    bus
);
    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

    state_t            state, state_nxt;
    logic [NSLV-1:0]   hit_vec;
    logic [NSLV-1:0]   cyc;
    logic              hit;
    logic              sel_ack, sel_err, tmo;
    logic              resp_err;
    logic [15:0]       cnt;
    logic [DW-1:0]     rdata;
    logic [DW-1:0]     cpu_dat;
    logic [AW-1:0]     s_adr, err_adr;
    logic [DW-1:0]     s_dat;
    logic [DW/8-1:0]   s_sel;
    logic              s_we;
    logic [7:0]        err_cnt;

    // Tag decode; scanning downward lets the lowest matching port win.
    always_comb begin
        hit_vec = '0;
        for (int i = NSLV - 1; i >= 0; i--) begin
            if (bus.cpu_adr_i[AW-1 -: 4] == SLV_TAGS[4*i +: 4]) begin
                hit_vec    = '0;
                hit_vec[i] = 1'b1;
            end
        end
    end

    assign hit = |hit_vec;

    // Only the selected port (the one whose cyc is up) is observed.
    always_comb begin
        rdata = '0;
        for (int i = 0; i < NSLV; i++) begin
            if (cyc[i]) rdata = bus.s_dat_i[DW*i +: DW];
        end
    end

    assign sel_ack = |(bus.s_ack_i & cyc);
    assign sel_err = |(bus.s_err_i & cyc);
    assign tmo     = (cnt == TMO_LAST);

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (bus.cpu_req_i) state_nxt = hit ? BUSY : RESP;
            BUSY: if (sel_err || sel_ack || tmo) state_nxt = RESP;
            RESP: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: request latch, port select, wait counter, response and status
    always_ff @(posedge clk) begin
        if (rst) begin
            cyc      <= '0;
            cnt      <= '0;
            resp_err <= 1'b0;
            cpu_dat  <= '0;
            s_adr    <= '0;
            s_dat    <= '0;
            s_sel    <= '0;
            s_we     <= 1'b0;
            err_adr  <= '0;
            err_cnt  <= '0;
        end else begin
            case (state)
                IDLE: if (bus.cpu_req_i) begin
                    s_adr    <= bus.cpu_adr_i;
                    s_dat    <= bus.cpu_dat_i;
                    s_sel    <= bus.cpu_sel_i;
                    s_we     <= bus.cpu_we_i;
                    cyc      <= hit_vec;
                    cnt      <= '0;
                    resp_err <= !hit;
                    if (!hit) begin
                        cpu_dat <= '0;
                        err_adr <= bus.cpu_adr_i;
                        if (err_cnt != 8'hff) err_cnt <= err_cnt + 8'd1;
                    end
                end
                BUSY: begin
                    // err beats ack; ack beats the timeout
                    if (sel_err || (!sel_ack && tmo)) begin
                        cyc      <= '0;
                        cnt      <= '0;
                        resp_err <= 1'b1;
                        cpu_dat  <= '0;
                        err_adr  <= s_adr;
                        if (err_cnt != 8'hff) err_cnt <= err_cnt + 8'd1;
                    end else if (sel_ack) begin
                        cyc      <= '0;
                        cnt      <= '0;
                        resp_err <= 1'b0;
                        if (!s_we) cpu_dat <= rdata;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Outputs: response pulses decoded from the RESP state, rest from registers
    always_comb begin
        bus.cpu_ready_o = (state == RESP) && !resp_err;
        bus.cpu_err_o   = (state == RESP) &&  resp_err;
        bus.cpu_dat_o   = cpu_dat;
        bus.s_cyc_o     = cyc;
        bus.s_stb_o     = cyc;
        bus.s_we_o      = s_we;
        bus.s_adr_o     = s_adr;
        bus.s_sel_o     = s_sel;
        bus.s_dat_o     = s_dat;
        bus.err_adr_o   = err_adr;
        bus.err_cnt_o   = err_cnt;
    end
endmodule

// File: tb/tb_biu_xbar.sv
// Self-checking bench for biu_xbar: per-transfer expectations are pushed to a
// scoreboard when the request is driven and popped on the ready/err pulse.
module tb_biu_xbar;
    localparam int NSLV = 4;
    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int TMO  = 4;
    // Tag table puts 0x0 on port 0, 0x3 on port 1, 0x2 on port 2, 0xC on port 3.
    localparam logic [15:0] TAGS = {4'hc, 4'h2, 4'h3, 4'h0};

    // Slave behaviour per transfer
    localparam int M_ACK = 0, M_ERR = 1, M_BOTH = 2, M_SILENT = 3, M_NOISE = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    biu_xbar_if #(.NSLV(NSLV), .AW(AW), .DW(DW)) bus ();

    biu_xbar #(.NSLV(NSLV), .AW(AW), .DW(DW), .SLV_TAGS(TAGS), .TIMEOUT(TMO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic          err;
        logic [DW-1:0] dat;
    } exp_t;

    exp_t          sb[$];
    int            checks = 0;
    int            errors = 0;
    logic [DW-1:0] m_dat;
    logic [AW-1:0] m_eadr;
    logic [7:0]    m_ecnt;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic int port_of(input logic [AW-1:0] a);
        logic [15:0] t;
        t = TAGS;
        for (int i = 0; i < NSLV; i++)
            if (a[AW-1 -: 4] == t[4*i +: 4]) return i;
        return -1;
    endfunction

    // One CPU transfer: model, drive, play the slave, check the response.
    task automatic xfer(input logic we, input logic [AW-1:0] adr, input logic [3:0] sel,
                        input logic [DW-1:0] dat, input int wt, input int mode,
                        input logic [DW-1:0] rd);
        int              p, lat, busy;
        logic            done;
        logic [NSLV-1:0] onehot;
        exp_t            e, got;

        @(negedge clk);
        chk("idle_quiet", {bus.cpu_ready_o, bus.cpu_err_o, |bus.s_cyc_o}, 3'b000);

        p      = port_of(adr);
        e.err  = (p < 0) || (mode == M_ERR) || (mode == M_BOTH) || (mode == M_SILENT);
        e.dat  = e.err ? '0 : (we ? m_dat : rd);
        m_dat  = e.dat;
        if (e.err) begin
            m_eadr = adr;
            if (m_ecnt != 8'hff) m_ecnt = m_ecnt + 8'd1;
        end
        sb.push_back(e);
        lat    = (p < 0) ? 1 : ((mode == M_SILENT) ? TMO + 1 : wt + 2);
        onehot = (p < 0) ? '0 : NSLV'(1) << p;

        bus.cpu_req_i = 1'b1;
        bus.cpu_we_i  = we;
        bus.cpu_adr_i = adr;
        bus.cpu_sel_i = sel;
        bus.cpu_dat_i = dat;
        for (int i = 0; i < NSLV; i++) bus.s_dat_i[DW*i +: DW] = $urandom;
        if (p >= 0) bus.s_dat_i[DW*p +: DW] = rd;

        done = 1'b0;
        busy = 0;
        for (int k = 1; k <= 40 && !done; k++) begin
            @(negedge clk);
            bus.s_ack_i = '0;
            bus.s_err_i = '0;
            if (bus.cpu_ready_o || bus.cpu_err_o) begin
                chk("latency", k, lat);
                chk("busy_cycles", busy, lat - 1);
                chk("ready_err_excl", bus.cpu_ready_o & bus.cpu_err_o, 1'b0);
                if (sb.size() == 0) begin
                    chk("sb_underflow", 1, 0);
                end else begin
                    got = sb.pop_front();
                    chk("resp_err", bus.cpu_err_o, got.err);
                    chk("cpu_dat", bus.cpu_dat_o, got.dat);
                end
                chk("err_cnt", bus.err_cnt_o, m_ecnt);
                if (bus.cpu_err_o) chk("err_adr", bus.err_adr_o, m_eadr);
                done = 1'b1;
                bus.cpu_req_i = 1'b0;
            end else if (bus.s_cyc_o != '0) begin
                busy++;
                chk("s_cyc", bus.s_cyc_o, onehot);
                chk("s_stb", bus.s_stb_o, onehot);
                chk("s_we",  bus.s_we_o, we);
                chk("s_adr", bus.s_adr_o, adr);
                chk("s_sel", bus.s_sel_o, sel);
                chk("s_dat", bus.s_dat_o, dat);
                // another port acking while port 0 is selected must be ignored
                if (mode == M_NOISE) bus.s_ack_i[1] = 1'b1;
                if (busy == wt + 1 && p >= 0) begin
                    case (mode)
                        M_ACK, M_NOISE: bus.s_ack_i[p] = 1'b1;
                        M_ERR:          bus.s_err_i[p] = 1'b1;
                        M_BOTH: begin
                            bus.s_ack_i[p] = 1'b1;
                            bus.s_err_i[p] = 1'b1;
                        end
                        default: ;
                    endcase
                end
            end
        end
        if (!done) begin
            chk("no_response", 0, 1);
            bus.cpu_req_i = 1'b0;
            bus.s_ack_i   = '0;
            bus.s_err_i   = '0;
        end
    endtask

    // Reset asserted during the second BUSY cycle of a read to port 2.
    task automatic reset_mid;
        @(negedge clk);
        bus.cpu_req_i = 1'b1;
        bus.cpu_we_i  = 1'b0;
        bus.cpu_adr_i = 32'h2000_0040;
        bus.cpu_sel_i = 4'hf;
        @(negedge clk);
        @(negedge clk);
        chk("rst_pre_cyc", bus.s_cyc_o, 4'b0100);
        rst = 1'b1;
        bus.cpu_req_i = 1'b0;
        @(negedge clk);
        chk("rst_cyc", bus.s_cyc_o, 4'b0000);
        chk("rst_stb", bus.s_stb_o, 4'b0000);
        chk("rst_pulse", {bus.cpu_ready_o, bus.cpu_err_o}, 2'b00);
        chk("rst_err_cnt", bus.err_cnt_o, 8'd0);
        chk("rst_dat", bus.cpu_dat_o, 32'd0);
        rst = 1'b0;
        m_dat = '0; m_eadr = '0; m_ecnt = '0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("post_rst_quiet", {bus.cpu_ready_o, bus.cpu_err_o, |bus.s_cyc_o}, 3'b000);
        end
    endtask

    initial begin
        logic [3:0] tl [5];
        int         p, md, wt;
        logic [3:0] tg;
        tl = '{4'h0, 4'h3, 4'h2, 4'hc, 4'h5};

        rst = 1'b1;
        bus.cpu_req_i = 1'b0; bus.cpu_we_i = 1'b0; bus.cpu_sel_i = '0;
        bus.cpu_adr_i = '0;   bus.cpu_dat_i = '0;
        bus.s_dat_i = '0;     bus.s_ack_i = '0;   bus.s_err_i = '0;
        m_dat = '0; m_eadr = '0; m_ecnt = '0;
        repeat (3) @(negedge clk);
        chk("reset_ready", bus.cpu_ready_o, 1'b0);
        chk("reset_err",   bus.cpu_err_o, 1'b0);
        chk("reset_cyc",   bus.s_cyc_o, 4'b0);
        chk("reset_stb",   bus.s_stb_o, 4'b0);
        chk("reset_dat",   bus.cpu_dat_o, 32'd0);
        chk("reset_adr",   bus.s_adr_o, 32'd0);
        chk("reset_ecnt",  bus.err_cnt_o, 8'd0);
        chk("reset_eadr",  bus.err_adr_o, 32'd0);
        rst = 1'b0;

        xfer(1'b0, 32'h3000_0010, 4'hf,    32'h0,        2, M_ACK,    32'hDEAD_BEEF);
        xfer(1'b1, 32'hC000_0004, 4'b0011, 32'h1234_5678, 0, M_ACK,   32'h0);
        xfer(1'b0, 32'h5000_0000, 4'hf,    32'h0,        0, M_ACK,    32'h0);
        xfer(1'b0, 32'h2000_0000, 4'hf,    32'h0,        0, M_SILENT, 32'h0);
        xfer(1'b0, 32'h0000_0100, 4'hf,    32'h0,        1, M_BOTH,   32'h1111_2222);
        xfer(1'b0, 32'h0000_0200, 4'hf,    32'h0,        2, M_NOISE,  32'hCAFE_F00D);
        xfer(1'b0, 32'h3000_0020, 4'hf,    32'h0,        0, M_ERR,    32'h5555_AAAA);
        // ack arriving in the last allowed BUSY cycle beats the timeout
        xfer(1'b0, 32'hC000_0008, 4'hf,    32'h0,        TMO - 1, M_ACK, 32'h0BAD_F00D);

        for (int n = 0; n < 12; n++) begin
            tg = tl[$urandom_range(0, 4)];
            md = $urandom_range(0, 4);
            wt = $urandom_range(0, TMO - 1);
            p  = port_of({tg, 28'h0});
            if (md == M_NOISE && p != 0) md = M_ACK;
            xfer(1'($urandom_range(0, 1)), {tg, 24'h0, 4'($urandom_range(0, 15))},
                 4'($urandom_range(1, 15)), $urandom, wt, md, $urandom);
        end

        reset_mid();

        for (int n = 0; n < 256; n++)
            xfer(1'b0, 32'h7000_0000 + 32'(n * 4), 4'hf, 32'h0, 0, M_ACK, 32'h0);
        chk("err_cnt_sat", bus.err_cnt_o, 8'd255);
        chk("sb_drained", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
